// File: rtl/timer_ctrl.sv
// ============================================================================
// timer_ctrl : MM:SS countdown timer controller (set / run / pause / expiry)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module timer_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       set_key,
  input  logic       inc_key,
  input  logic       clr_key,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [1:0] edit_sel,
  output logic [2:0] state,
  output logic       sec_tick,
  output logic       alarm
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic [1:0]    edit_sel_q, edit_sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d;
  logic          alarm_q, alarm_d;
  logic          is_zero, is_one;

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] top);
    return (d == top) ? 4'd0 : d + 4'd1;
  endfunction

  assign is_zero = (sec_lo_q == 4'd0) && (sec_hi_q == 4'd0) &&
                   (min_lo_q == 4'd0) && (min_hi_q == 4'd0);
  assign is_one  = (sec_lo_q == 4'd1) && (sec_hi_q == 4'd0) &&
                   (min_lo_q == 4'd0) && (min_hi_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    sec_lo_d   = sec_lo_q;
    sec_hi_d   = sec_hi_q;
    min_lo_d   = min_lo_q;
    min_hi_d   = min_hi_q;
    edit_sel_d = edit_sel_q;
    presc_d    = '0;
    sec_tick_d = 1'b0;

    if (clr_key) begin
      state_d    = ST_IDLE;
      sec_lo_d   = 4'd0;
      sec_hi_d   = 4'd0;
      min_lo_d   = 4'd0;
      min_hi_d   = 4'd0;
      edit_sel_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop) begin
            if (!is_zero) state_d = ST_RUN;
          end else if (set_key) begin
            state_d    = ST_SET;
            edit_sel_d = 2'd0;
          end
        end
        ST_SET: begin
          // start_stop is swallowed here, and still masks the lower-priority keys
          if (!start_stop) begin
            if (set_key) begin
              if (edit_sel_q == 2'd3) begin
                edit_sel_d = 2'd0;
                state_d    = ST_IDLE;
              end else begin
                edit_sel_d = edit_sel_q + 2'd1;
              end
            end else if (inc_key) begin
              case (edit_sel_q)
                2'd0:    sec_lo_d = wrap_inc(sec_lo_q, 4'd9);
                2'd1:    sec_hi_d = wrap_inc(sec_hi_q, 4'd5);
                2'd2:    min_lo_d = wrap_inc(min_lo_q, 4'd9);
                default: min_hi_d = wrap_inc(min_hi_q, 4'd5);
              endcase
            end
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            sec_tick_d = 1'b1;
            if (is_one) state_d = ST_DONE;
            // BCD borrow chain; 00:00 is never reached in RUN, so min_hi cannot underflow
            if (sec_lo_q != 4'd0) begin
              sec_lo_d = sec_lo_q - 4'd1;
            end else begin
              sec_lo_d = 4'd9;
              if (sec_hi_q != 4'd0) begin
                sec_hi_d = sec_hi_q - 4'd1;
              end else begin
                sec_hi_d = 4'd5;
                if (min_lo_q != 4'd0) begin
                  min_lo_d = min_lo_q - 4'd1;
                end else begin
                  min_lo_d = 4'd9;
                  min_hi_d = min_hi_q - 4'd1;
                end
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start_stop || set_key || inc_key) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    alarm_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sec_lo_q   <= 4'd0;
      sec_hi_q   <= 4'd0;
      min_lo_q   <= 4'd0;
      min_hi_q   <= 4'd0;
      edit_sel_q <= 2'd0;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_lo_q   <= sec_lo_d;
      sec_hi_q   <= sec_hi_d;
      min_lo_q   <= min_lo_d;
      min_hi_q   <= min_hi_d;
      edit_sel_q <= edit_sel_d;
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      alarm_q    <= alarm_d;
    end
  end

  assign sec_lo   = sec_lo_q;
  assign sec_hi   = sec_hi_q;
  assign min_lo   = min_lo_q;
  assign min_hi   = min_hi_q;
  assign edit_sel = edit_sel_q;
  assign state    = state_q;
  assign sec_tick = sec_tick_q;
  assign alarm    = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// tb_timer_ctrl : directed vector table plus hand-written corner sequences
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  localparam logic [3:0] K_N = 4'b0000;
  localparam logic [3:0] K_S = 4'b1000;
  localparam logic [3:0] K_T = 4'b0100;
  localparam logic [3:0] K_I = 4'b0010;
  localparam logic [3:0] K_C = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0, set_key = 1'b0, inc_key = 1'b0, clr_key = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic [1:0] edit_sel;
  logic [2:0] state;
  logic       sec_tick, alarm;

  int n_pass = 0;
  int n_total = 0;

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_stop(start_stop), .set_key(set_key), .inc_key(inc_key), .clr_key(clr_key),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .edit_sel(edit_sel), .state(state), .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;
    logic [2:0] st;
    logic [1:0] es;
    logic [3:0] mh, ml, sh, sl;
    logic       tk, al;
  } vec_t;

  vec_t vt[22];

  task automatic cyc(input logic [3:0] k);
    @(negedge clk);
    {start_stop, set_key, inc_key, clr_key} = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] st, input logic [1:0] es,
                       input logic [3:0] mh, ml, sh, sl, input logic tk, al);
    logic [22:0] got, exp;
    got = {state, edit_sel, min_hi, min_lo, sec_hi, sec_lo, sec_tick, alarm};
    exp = {st, es, mh, ml, sh, sl, tk, al};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got st=%0d es=%0d %h%h:%h%h tick=%b alarm=%b, expected st=%0d es=%0d %h%h:%h%h tick=%b alarm=%b",
                  nm, state, edit_sel, min_hi, min_lo, sec_hi, sec_lo, sec_tick, alarm,
                  st, es, mh, ml, sh, sl, tk, al);
  endtask

  // Enter a value through SET mode, ending back in IDLE with edit_sel 0
  task automatic load(input int mh, ml, sh, sl);
    cyc(K_T); repeat (sl) cyc(K_I);
    cyc(K_T); repeat (sh) cyc(K_I);
    cyc(K_T); repeat (ml) cyc(K_I);
    cyc(K_T); repeat (mh) cyc(K_I);
    cyc(K_T);
  endtask

  initial begin
    //          keys     st    es    mh    ml    sh    sl    tk    al
    vt[0]  = '{K_T,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[1]  = '{K_I,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0};
    vt[2]  = '{K_I,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0};
    vt[3]  = '{K_I,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0};
    vt[4]  = '{K_T,      3'd1, 2'd1, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0};
    vt[5]  = '{K_I,      3'd1, 2'd1, 4'd0, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0};
    vt[6]  = '{K_I,      3'd1, 2'd1, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[7]  = '{K_T,      3'd1, 2'd2, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[8]  = '{K_T,      3'd1, 2'd3, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[9]  = '{K_T,      3'd0, 2'd0, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[10] = '{K_S,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[11] = '{K_N,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[12] = '{K_N,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[13] = '{K_N,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0};
    vt[14] = '{K_N,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd2, 1'b1, 1'b0};
    vt[15] = '{K_N,      3'd2, 2'd0, 4'd0, 4'd0, 4'd2, 4'd2, 1'b0, 1'b0};
    vt[16] = '{K_S | K_C, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[17] = '{K_S,      3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[18] = '{K_I,      3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[19] = '{K_T,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[20] = '{K_S,      3'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[21] = '{K_C,      3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset", 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cyc(vt[i].keys);
      check($sformatf("vec%0d", i), vt[i].st, vt[i].es, vt[i].mh, vt[i].ml,
            vt[i].sh, vt[i].sl, vt[i].tk, vt[i].al);
    end

    // Countdown with borrow from 01:00
    load(0, 1, 0, 0);
    cyc(K_S); repeat (3) cyc(K_N);
    check("borrow_pre", 3'd2, 2'd0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(K_N);
    check("borrow_59", 3'd2, 2'd0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
    repeat (3) cyc(K_N);
    cyc(K_N);
    check("borrow_58", 3'd2, 2'd0, 4'd0, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0);
    cyc(K_C);

    // Expiry from 00:02
    load(0, 0, 0, 2);
    cyc(K_S); repeat (3) cyc(K_N);
    cyc(K_N);
    check("exp_01", 3'd2, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    repeat (3) cyc(K_N);
    cyc(K_N);
    check("exp_done", 3'd4, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc(K_N);
    check("exp_hold", 3'd4, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc(K_I);
    check("exp_ack", 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Pause at prescaler=2, hold, resume
    load(0, 0, 1, 0);
    cyc(K_S); cyc(K_N); cyc(K_N);
    cyc(K_S);
    check("pause", 3'd3, 2'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(K_N);
      check($sformatf("frozen%0d", i), 3'd3, 2'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
    end
    cyc(K_S); repeat (3) cyc(K_N);
    check("resume_pre", 3'd2, 2'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
    cyc(K_N);
    check("resume_09", 3'd2, 2'd0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    cyc(K_C);

    // start_stop on the wrap cycle: pause wins, no decrement
    load(0, 0, 0, 5);
    cyc(K_S); repeat (3) cyc(K_N);
    cyc(K_S);
    check("wrap_pause", 3'd3, 2'd0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
    // clr_key on the wrap cycle: clear wins, no tick
    cyc(K_S); repeat (3) cyc(K_N);
    cyc(K_C);
    check("wrap_clr", 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Tens digits wrap 5 -> 0
    cyc(K_T); cyc(K_T);
    repeat (5) cyc(K_I);
    check("sh_5", 3'd1, 2'd1, 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    cyc(K_I);
    check("sh_wrap", 3'd1, 2'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(K_T); cyc(K_T);
    repeat (5) cyc(K_I);
    check("mh_5", 3'd1, 2'd3, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(K_I);
    check("mh_wrap", 3'd1, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(K_T);

    // Asynchronous reset mid-run at 12:34
    load(1, 2, 3, 4);
    cyc(K_S); cyc(K_N); cyc(K_N);
    check("pre_rst", 3'd2, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(K_N);
    check("post_rst", 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Countdown-timer controller for the MM:SS timer display. It owns four BCD digit registers: seconds units 0-9, seconds tens 0-5, minutes units 0-9 and minutes tens 0-5. It sequences them through set, run, pause and expiry under four one-cycle key pulses. A prescaler generates the 1 Hz decrement tick, and the block drives the display digits and the alarm output.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per second tick; legal values are ≥ 2.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_stop  in  1  one-cycle pulse: start, pause or resume
- set_key  in  1  one-cycle pulse: enter set mode / advance edited digit
- inc_key  in  1  one-cycle pulse: increment the edited digit
- clr_key  in  1  one-cycle pulse: clear to 00:00 and go idle
- sec_lo  out  4  seconds units, BCD 0-9
- sec_hi  out  4  seconds tens, BCD 0-5
- min_lo  out  4  minutes units, BCD 0-9
- min_hi  out  4  minutes tens, BCD 0-5
- edit_sel  out  2  digit under edit: 0=sec_lo, 1=sec_hi, 2=min_lo, 3=min_hi
- state  out  3  FSM state: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
- sec_tick  out  1  one-cycle pulse on each countdown decrement
- alarm  out  1  high while in DONE

## Operation
- Reset values: all digits 0, edit_sel 0, state IDLE, sec_tick 0, alarm 0, prescaler 0.
- Key priority when several keys are high in the same cycle: clr_key > start_stop > set_key > inc_key. Only the highest-priority key acts; the others are dropped.
- clr_key, in any state: digits 0, edit_sel 0, prescaler 0, state IDLE.
- IDLE:
  - start_stop with a nonzero value: go to RUN.
  - start_stop with value 00:00: ignored.
  - set_key: go to SET with edit_sel=0.
  - inc_key: ignored.
- SET:
  - inc_key increments the selected digit. Units digits wrap 9→0; tens digits wrap 5→0. There is no carry into neighbouring digits.
  - set_key with edit_sel<3: edit_sel increments.
  - set_key with edit_sel=3: edit_sel returns to 0 and state goes to IDLE.
  - start_stop: ignored.
- RUN:
  - start_stop: go to PAUSE.
  - set_key, inc_key: ignored.
  - On each prescaler wrap, the value decrements by one second with BCD borrow: sec_lo 0→9 borrows from sec_hi, sec_hi 0→5 borrows from min_lo, min_lo 0→9 borrows from min_hi.
  - A decrement that reaches 00:00 moves the FSM to DONE on the same edge.
- PAUSE:
  - start_stop: go to RUN.
  - Digits hold; set_key and inc_key are ignored.
- DONE:
  - alarm=1 and digits hold 00:00.
  - start_stop, set_key or inc_key returns to IDLE, with alarm=0 on the next cycle.
- Prescaler behaviour:
  - Counts 0..TICK_DIV-1 only while in RUN.
  - Forced to 0 in every other state, so a pause discards the partial second.
  - Wraps to 0 after TICK_DIV-1.
- Legal range is 00:00-59:59; the value never underflows.

## Timing
- All outputs are registered; a key sampled at edge N takes effect at the outputs after edge N.
- Start-to-first-decrement: after the edge entering RUN, the prescaler counts 0..TICK_DIV-1. The first decrement occurs at the TICK_DIV-th following edge. Subsequent decrements follow every TICK_DIV cycles.
- sec_tick is high for exactly the one cycle after each decrement edge. This includes the final 00:01→00:00 decrement, in which state=DONE and alarm=1 appear in that same cycle.
- A start_stop pulse coinciding with a prescaler wrap: pause wins; no decrement happens and sec_tick stays 0.
- A clr_key pulse coinciding with a wrap: clear wins; digits become 0 and no tick is issued.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes at the first clk edge after deassertion.

## Test plan
- Set value, TICK_DIV=4: set_key, inc ×3, set_key, inc ×2, set_key ×3 → state IDLE, edit_sel 0, digits sec_lo=3, sec_hi=2, min=00 (00:23).
- Countdown with borrow: load 01:00, start_stop → after 4 cycles value 00:59 with one sec_tick pulse; after 4 more cycles, 00:58.
- Expiry: load 00:02, start → 00:01 at cycle 4, 00:00 with state=4, alarm=1 and sec_tick=1 at cycle 8; inc_key → state 0, alarm 0.
- Pause/resume: start from 00:10, start_stop at prescaler=2 → state 3, digits frozen for 20 cycles; start_stop → next decrement exactly 4 cycles after resume.
- Edge cases:
  - start_stop in IDLE at 00:00: stays IDLE.
  - inc_key on sec_hi=5 and min_hi=5: both wrap to 0.
  - clr_key together with start_stop in RUN: IDLE, 00:00.
- Async reset mid-RUN at 12:34: all outputs 0 and state IDLE without waiting for a clk edge.
